// File: rtl/ir_sequencer.sv
// ir_sequencer: six-T-state fetch/execute controller driving IR and datapath strobes.
// Define SEQ_JZ_EN to decode OPC_JZ as a jump taken when zero_flag is set.
module ir_sequencer #(
    parameter logic [3:0] OPC_LDA = 4'h0,
    parameter logic [3:0] OPC_ADD = 4'h1,
    parameter logic [3:0] OPC_SUB = 4'h2,
    parameter logic [3:0] OPC_JMP = 4'h3,
    parameter logic [3:0] OPC_JZ  = 4'h4,
    parameter logic [3:0] OPC_OUT = 4'hE,
    parameter logic [3:0] OPC_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    output logic [5:0] t_state,
    output logic       halted,
    output logic       PC_out,
    output logic       PC_inc,
    output logic       PC_load,
    output logic       MAR_in,
    output logic       RAM_out,
    output logic       IR_in,
    output logic       IR_out,
    output logic       A_in,
    output logic       A_out,
    output logic       B_in,
    output logic       ALU_out,
    output logic       SUB,
    output logic       OUT_in
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;
    state_t r_state, w_next;
    logic w_lda, w_add, w_sub, w_jmp, w_out, w_hlt, w_jz_take;
    assign w_lda = opcode == OPC_LDA;
    assign w_add = opcode == OPC_ADD;
    assign w_sub = opcode == OPC_SUB;
    assign w_jmp = opcode == OPC_JMP;
    assign w_out = opcode == OPC_OUT;
    assign w_hlt = opcode == OPC_HLT;
`ifdef SEQ_JZ_EN
    assign w_jz_take = (opcode == OPC_JZ) && zero_flag;
`else
    assign w_jz_take = (opcode == OPC_JZ) & zero_flag & 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = run ? S_T1 : S_IDLE;
            S_T1:    w_next = S_T2;
            S_T2:    w_next = S_T3;
            S_T3:    w_next = S_T4;
            S_T4:    w_next = w_hlt ? S_HALT : S_T5;
            S_T5:    w_next = S_T6;
            S_T6:    w_next = S_T1;
            default: w_next = S_HALT;
        endcase
    end
    always_comb begin
        t_state = (r_state >= S_T1 && r_state <= S_T6) ? 6'b1 << (r_state - S_T1) : 6'b0;
        halted  = r_state == S_HALT;
        PC_out  = r_state == S_T1;
        PC_inc  = r_state == S_T2;
        IR_in   = r_state == S_T3;
        MAR_in  = (r_state == S_T1) || (r_state == S_T4 && (w_lda || w_add || w_sub));
        IR_out  = (r_state == S_T3) || (r_state == S_T4 && (w_lda || w_add || w_sub || w_jmp || w_jz_take));
        PC_load = r_state == S_T4 && (w_jmp || w_jz_take);
        A_out   = r_state == S_T4 && w_out;
        OUT_in  = r_state == S_T4 && w_out;
        RAM_out = (r_state == S_T3) || (r_state == S_T5 && (w_lda || w_add || w_sub));
        B_in    = r_state == S_T5 && (w_add || w_sub);
        A_in    = (r_state == S_T5 && w_lda) || (r_state == S_T6 && (w_add || w_sub));
        ALU_out = r_state == S_T6 && (w_add || w_sub);
        SUB     = (r_state == S_T5 || r_state == S_T6) && w_sub;
    end
endmodule

// File: tb/tb_ir_sequencer.sv
// tb_ir_sequencer: directed scoreboard bench for ir_sequencer (SEQ_JZ_EN-aware).
module tb_ir_sequencer;
    logic clk = 0, rst = 1, run = 0, zero_flag = 0;
    logic [3:0] opcode = 4'h0;
    logic [5:0] t_state;
    logic halted, PC_out, PC_inc, PC_load, MAR_in, RAM_out, IR_in, IR_out;
    logic A_in, A_out, B_in, ALU_out, SUB, OUT_in;
    int passed = 0, total = 0;
    logic [19:0] sb[$];

    localparam logic [19:0] OUTI = 20'h1 << 0,  SUBB = 20'h1 << 1,  ALUO = 20'h1 << 2;
    localparam logic [19:0] BI   = 20'h1 << 3,  AO   = 20'h1 << 4,  AI   = 20'h1 << 5;
    localparam logic [19:0] IRO  = 20'h1 << 6,  IRI  = 20'h1 << 7,  RAMO = 20'h1 << 8;
    localparam logic [19:0] MARI = 20'h1 << 9,  PCL  = 20'h1 << 10, PCI  = 20'h1 << 11;
    localparam logic [19:0] PCO  = 20'h1 << 12, HLTD = 20'h1 << 13;
`ifdef SEQ_JZ_EN
    localparam logic [19:0] JZ_TAKEN = IRO | PCL;
`else
    localparam logic [19:0] JZ_TAKEN = 20'h0;
`endif

    ir_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero_flag(zero_flag),
        .t_state(t_state), .halted(halted), .PC_out(PC_out), .PC_inc(PC_inc),
        .PC_load(PC_load), .MAR_in(MAR_in), .RAM_out(RAM_out), .IR_in(IR_in),
        .IR_out(IR_out), .A_in(A_in), .A_out(A_out), .B_in(B_in),
        .ALU_out(ALU_out), .SUB(SUB), .OUT_in(OUT_in)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] T(int n);
        return 20'h1 << (13 + n);
    endfunction

    function automatic logic [19:0] obs();
        return {t_state, halted, PC_out, PC_inc, PC_load, MAR_in, RAM_out, IR_in,
                IR_out, A_in, A_out, B_in, ALU_out, SUB, OUT_in};
    endfunction

    task automatic cmp(input string tag);
        logic [19:0] e, o;
        e = sb.pop_front();
        o = obs();
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: observed %05h expected %05h", tag, o, e);
    endtask

    // Expected word goes on the scoreboard now, compared at the next falling edge.
    task automatic step(input string tag, input logic [19:0] e);
        sb.push_back(e);
        @(negedge clk);
        cmp(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic now(input string tag, input logic [19:0] e);
        sb.push_back(e);
        cmp(tag);
    endtask

    // Fetch with a junk opcode on the IR bus, then publish the real opcode for T4.
    task automatic fetch(input logic [3:0] op);
        opcode = 4'h9;
        step("T1", T(1) | PCO | MARI);
        opcode = 4'h2;
        step("T2", T(2) | PCI);
        step("T3", T(3) | RAMO | IRI | IRO);
        opcode = op;
    endtask

    always @(negedge clk) begin
        total++;
        assert ($countones({PC_out, RAM_out, A_out, ALU_out}) <= 1) passed++;
        else $error("FAIL bus_drivers: observed %b expected at most one", {PC_out, RAM_out, A_out, ALU_out});
    end

    initial begin
        #2;
        now("reset_hold", 20'h0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 5; i++) step("idle", 20'h0);
        run = 1;
        step("idle_run", 20'h0);
        run = 0;
        fetch(4'h1);
        step("add_T4", T(4) | IRO | MARI);
        step("add_T5", T(5) | RAMO | BI);
        step("add_T6", T(6) | ALUO | AI);
        fetch(4'h2);
        step("sub_T4", T(4) | IRO | MARI);
        step("sub_T5", T(5) | RAMO | BI | SUBB);
        step("sub_T6", T(6) | ALUO | AI | SUBB);
        fetch(4'h3);
        step("jmp_T4", T(4) | IRO | PCL);
        step("jmp_T5", T(5));
        step("jmp_T6", T(6));
        fetch(4'hE);
        step("out_T4", T(4) | AO | OUTI);
        step("out_T5", T(5));
        step("out_T6", T(6));
        zero_flag = 1;
        fetch(4'h4);
        step("jz1_T4", T(4) | JZ_TAKEN);
        step("jz1_T5", T(5));
        step("jz1_T6", T(6));
        zero_flag = 0;
        fetch(4'h4);
        step("jz0_T4", T(4));
        step("jz0_T5", T(5));
        step("jz0_T6", T(6));
        fetch(4'h7);
        step("nop_T4", T(4));
        step("nop_T5", T(5));
        step("nop_T6", T(6));
        fetch(4'h0);
        step("lda_T4", T(4) | IRO | MARI);
        #2;
        now("lda_T5", T(5) | RAMO | AI);
        rst = 1;
        #1;
        now("lda_T5_rst", 20'h0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 3; i++) step("idle_after_rst", 20'h0);
        run = 1;
        step("idle_run2", 20'h0);
        fetch(4'hF);
        step("hlt_T4", T(4));
        for (int i = 0; i < 20; i++) step("halt", HLTD);
        rst = 1;
        #1;
        now("halt_rst", 20'h0);
        @(posedge clk); #1;
        rst = 0;
        run = 0;
        step("idle_after_halt", 20'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
